fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-issue RISC-V core. Owns the program counter, drives the byte address of the combinational-read instruction memory, and buffers fetched words with their PCs in a small FIFO. Presents them to the decode stage over a valid/ready handshake. Accepts a redirect (branch/jump target) from execute that flushes all buffered fetches.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width.
- `ADDRESS_WIDTH`, 32, PC and instruction-memory address width.
- `RESET_PC`, 32'hBFC00000, PC loaded on reset (instruction ROM base).
- `FIFO_DEPTH`, 2, number of buffered {pc, instr} entries; power of two, ≥ 2.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out ADDRESS_WIDTH: byte address to instruction memory; always equals the current PC register.
- `imem_rd` in DATA_WIDTH: instruction word returned combinationally for `imem_addr` in the same cycle.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in ADDRESS_WIDTH: target PC; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: FIFO head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out DATA_WIDTH: head instruction word.
- `out_pc` out ADDRESS_WIDTH: PC of the head instruction.
- `out_pc_plus4` out ADDRESS_WIDTH: `out_pc + 4`, modulo 2^ADDRESS_WIDTH.

## Operation
- State:
  - PC register.
  - FIFO of FIFO_DEPTH entries {pc, instr}.
  - Read pointer, write pointer, and occupancy count, width `$clog2(FIFO_DEPTH+1)`.
- `pop` = `out_valid & out_ready`.
- `push` = `!redirect_valid & (count < FIFO_DEPTH | pop)`. Push is allowed when the FIFO is full and popping in the same cycle.
- On push:
  - The entry {PC, imem_rd} is written at the write pointer.
  - PC <= PC + 4, wrapping modulo 2^ADDRESS_WIDTH.
- When the FIFO is full without a pop, PC holds. `imem_addr` stays at the held PC; re-reading it is harmless.
- Redirect has highest priority:
  - The FIFO is flushed: count <= 0 and pointers <= 0.
  - PC <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - No push occurs that cycle.
  - If a pop coincides with a redirect, the pop still completes: decode has consumed the head, and the flush discards the rest.
- Pointers wrap modulo FIFO_DEPTH.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither. Redirect overrides all of these.
- `out_valid` = (count != 0).
- `out_instr`, `out_pc`, and `out_pc_plus4` are driven from the head entry. All three are forced to 0 while `out_valid` is 0.
- Reset:
  - PC <= RESET_PC, count and pointers <= 0, FIFO contents <= 0.
  - `rst` overrides `redirect_valid`.

## Timing
- Reset values of outputs: `imem_addr` = RESET_PC; `out_valid`, `out_instr`, `out_pc` = 0. `out_pc_plus4` = 0, because it is forced with the head.
- Fetch latency: a PC value presented on `imem_addr` in cycle N appears at the FIFO head no earlier than cycle N+1.
- First fetch: `rst` is high in cycle 0 and low in cycle 1.
  - Cycle 1: push of RESET_PC.
  - Cycle 2: `out_valid` = 1 with `out_pc` = RESET_PC.
- Throughput: with `out_ready` held high, one instruction per cycle in steady state, in sequential PC order.
- Redirect asserted in cycle N:
  - `out_valid` = 0 in cycle N+1, while the target is fetched.
  - Target appears at the head in cycle N+2.
- Backpressure: `out_ready` low for K cycles fills the FIFO after FIFO_DEPTH pushes. Then PC stalls and no entry is lost or duplicated.
- Head outputs are stable while `out_valid & !out_ready`.
- Handshake: `out_valid` never depends combinationally on `out_ready`.

## Test plan
- Reset and stream:
  - Stimulus: imem returns `{pc}` as data; `out_ready` = 1.
  - Required: after reset, `out_pc` = BFC00000, BFC00004, BFC00008 on consecutive cycles starting cycle 2, with `out_instr` == `out_pc` each cycle and `out_pc_plus4` correct.
- Backpressure:
  - Stimulus: drop `out_ready` for 5 cycles mid-stream.
  - Required: count saturates at 2 and `imem_addr` holds. On release, PCs continue with no gap and no duplicate.
- Redirect:
  - Stimulus: `redirect_valid` with `redirect_pc` = BFC00040 while the FIFO is full.
  - Required: `out_valid` = 0 next cycle, then `out_pc` = BFC00040, then BFC00044.
- Redirect with pop and misaligned target:
  - Stimulus: redirect to BFC00023 in the same cycle as a pop.
  - Required: the popped instruction is counted as accepted; the next head is BFC00020.
- Reset mid-operation:
  - Stimulus: assert `rst` with a full FIFO and `redirect_valid` = 1.
  - Required: next cycle `out_valid` = 0, all head outputs 0, and `imem_addr` = BFC00000.
- PC wrap:
  - Stimulus: redirect to FFFFFFFC.
  - Required: heads FFFFFFFC then 00000000, with `out_pc_plus4` of the first = 00000000.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect from execute, and the
// valid/ready instruction stream toward decode.
interface fetch_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_rd;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic [ADDRESS_WIDTH-1:0] out_pc;
    logic [ADDRESS_WIDTH-1:0] out_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational imem and buffers
// {pc, instr} pairs in a small FIFO toward decode; redirects flush the FIFO.
module fetch_unit #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC00000,
    parameter int                       FIFO_DEPTH    = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] mem_pc_q    [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_pc_d    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_instr_d [FIFO_DEPTH];

    logic                     out_valid;
    logic                     pop;
    logic                     push;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic [ADDRESS_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0]    head_instr;

    always_comb begin
        out_valid       = (count_q != '0);
        pop             = out_valid & bus.out_ready;
        push            = !bus.redirect_valid & ((count_q < DEPTH_C) | pop);
        redirect_target = bus.redirect_pc & ~ADDRESS_WIDTH'(3);

        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;

        if (bus.redirect_valid) begin
            // Flush: the concurrent pop (if any) is already consumed by decode.
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]    = pc_q;
                mem_instr_d[wr_ptr_q] = bus.imem_rd;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                pc_d                  = pc_q + ADDRESS_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

    // Head outputs are zeroed whenever the FIFO is empty.
    assign head_pc    = mem_pc_q[rd_ptr_q];
    assign head_instr = mem_instr_q[rd_ptr_q];

    assign bus.imem_addr    = pc_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = out_valid ? head_pc : '0;
    assign bus.out_instr    = out_valid ? head_instr : '0;
    assign bus.out_pc_plus4 = out_valid ? (head_pc + ADDRESS_WIDTH'(4)) : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference FIFO model is filled on each
// modelled push and drained on each accepted pop, checked against the DUT every cycle.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    fetch_unit #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // The instruction memory returns the address itself as data.
    assign bus.imem_rd = bus.imem_addr;

    int n_checks = 0;
    int n_errors = 0;
    int n_accepted = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] head;
        logic        vld;
        vld  = (exp_q.size() != 0);
        head = vld ? exp_q[0] : 32'h0;
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, vld});
        chk("out_pc", bus.out_pc, head);
        chk("out_instr", bus.out_instr, head);
        chk("out_pc_plus4", bus.out_pc_plus4, vld ? head + 32'd4 : 32'h0);
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit pop_m;
        bit push_m;
        @(negedge clk);
        if (m_ok) compare_outputs();
        rst                = r;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC;
            exp_q.delete();
            m_ok = 1'b1;
        end else begin
            pop_m  = (exp_q.size() != 0) && rdy;
            push_m = !rv && ((exp_q.size() < DEPTH) || pop_m);
            if (pop_m) begin
                void'(exp_q.pop_front());
                n_accepted++;
            end
            if (rv) begin
                exp_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else if (push_m) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset and streaming
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Backpressure mid-stream, then release
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Redirect while full
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hBFC00040);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Redirect coinciding with a pop, misaligned target
        step(0, 1, 1, 32'hBFC00023);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Reset while full with redirect asserted
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 1, 32'h12345678);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // PC wrap
        step(0, 1, 1, 32'hFFFFFFFC);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            logic        rv;
            logic [31:0] tgt;
            rv  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            step(0, 1'($urandom_range(0, 1)), rv, tgt);
        end
        step(0, 1, 0, 0);

        @(negedge clk);
        compare_outputs();
        chk("accepted_nonzero", {31'b0, (n_accepted > 20)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
